// File: rtl/uart_cmd_parser.sv
// Host command responder: decodes 6-byte A5 frames from the UART into EEPROM
// requests and returns a paced 3-byte 5A response through the transmitter.
module uart_cmd_parser #(
   parameter int unsigned byte_gap  = 2200,
   parameter int unsigned timeout   = 500000,
   parameter int unsigned cnt_width = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_dat,
   input  logic        rx_rdy,
   output logic        tx_en,
   output logic [7:0]  tx_dat,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_wr,
   output logic [15:0] cmd_addr,
   output logic [7:0]  cmd_wdat,
   input  logic        cmd_done,
   input  logic [7:0]  cmd_rdat,
   output logic [7:0]  err_cnt
);

   localparam logic [7:0] SOF_RX  = 8'hA5;
   localparam logic [7:0] SOF_TX  = 8'h5A;
   localparam logic [7:0] OP_WR   = 8'h01;
   localparam logic [7:0] OP_RD   = 8'h02;
   localparam logic [7:0] ST_OK   = 8'h00;
   localparam logic [7:0] ST_CHK  = 8'hE1;
   localparam logic [7:0] ST_CMD  = 8'hE2;
   localparam logic [7:0] ST_TMO  = 8'hE3;
   localparam logic [cnt_width-1:0] TMO_LAST   = cnt_width'(timeout);
   localparam logic [cnt_width-1:0] GAP_LAST   = cnt_width'(byte_gap - 1);
   // RESP2 lasts one cycle, so DRAIN covers the remaining byte_gap-1 cycles
   localparam logic [cnt_width-1:0] DRAIN_LAST = cnt_width'(byte_gap - 2);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADRH, S_ADRL, S_DATA, S_CHK,
      S_ISSUE, S_WAIT, S_RESP0, S_RESP1, S_RESP2, S_DRAIN
   } state_t;

   state_t                 state_q, state_d;
   logic [cnt_width-1:0]   cnt_q, cnt_d;
   logic [7:0]             op_q, op_d;
   logic [7:0]             chk_q, chk_d;
   logic [7:0]             status_q, status_d;
   logic [7:0]             rdata_q, rdata_d;
   logic                   tx_en_q, tx_en_d;
   logic [7:0]             tx_dat_q, tx_dat_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic                   cmd_wr_q, cmd_wr_d;
   logic [15:0]            cmd_addr_q, cmd_addr_d;
   logic [7:0]             cmd_wdat_q, cmd_wdat_d;
   logic [7:0]             err_cnt_q, err_cnt_d;
   logic                   resp_start;
   logic                   tmo;
   logic                   gap_done;

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + cnt_width'(1);
      op_d        = op_q;
      chk_d       = chk_q;
      status_d    = status_q;
      rdata_d     = rdata_q;
      tx_en_d     = 1'b0;
      tx_dat_d    = tx_dat_q;
      cmd_valid_d = cmd_valid_q;
      cmd_wr_d    = cmd_wr_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdat_d  = cmd_wdat_q;
      err_cnt_d   = err_cnt_q;
      resp_start  = 1'b0;
      tmo         = (cnt_q >= TMO_LAST);
      gap_done    = (cnt_q >= GAP_LAST);

      case (state_q)
         S_IDLE: begin
            if (rx_rdy && (rx_dat == SOF_RX)) state_d = S_CMD;
         end
         S_CMD: begin
            if (rx_rdy) begin
               op_d    = rx_dat;
               chk_d   = rx_dat;
               state_d = S_ADRH;
            end else if (tmo) begin
               state_d = S_IDLE;
            end
         end
         S_ADRH: begin
            if (rx_rdy) begin
               cmd_addr_d[15:8] = rx_dat;
               chk_d            = chk_q ^ rx_dat;
               state_d          = S_ADRL;
            end else if (tmo) begin
               state_d = S_IDLE;
            end
         end
         S_ADRL: begin
            if (rx_rdy) begin
               cmd_addr_d[7:0] = rx_dat;
               chk_d           = chk_q ^ rx_dat;
               state_d         = S_DATA;
            end else if (tmo) begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (rx_rdy) begin
               cmd_wdat_d = rx_dat;
               chk_d      = chk_q ^ rx_dat;
               state_d    = S_CHK;
            end else if (tmo) begin
               state_d = S_IDLE;
            end
         end
         S_CHK: begin
            // checksum error outranks an unknown opcode
            if (rx_rdy) begin
               if ((chk_q ^ rx_dat) != 8'h00) begin
                  status_d   = ST_CHK;
                  rdata_d    = 8'h00;
                  resp_start = 1'b1;
               end else if ((op_q != OP_WR) && (op_q != OP_RD)) begin
                  status_d   = ST_CMD;
                  rdata_d    = 8'h00;
                  resp_start = 1'b1;
               end else begin
                  cmd_valid_d = 1'b1;
                  cmd_wr_d    = (op_q == OP_WR);
                  state_d     = S_ISSUE;
               end
            end else if (tmo) begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cmd_done) begin
               status_d   = ST_OK;
               rdata_d    = cmd_wr_q ? cmd_wdat_q : cmd_rdat;
               resp_start = 1'b1;
            end else if (tmo) begin
               status_d   = ST_TMO;
               rdata_d    = 8'h00;
               resp_start = 1'b1;
            end
         end
         S_RESP0: begin
            if (gap_done) begin
               tx_en_d  = 1'b1;
               tx_dat_d = status_q;
               state_d  = S_RESP1;
            end
         end
         S_RESP1: begin
            if (gap_done) begin
               tx_en_d  = 1'b1;
               tx_dat_d = rdata_q;
               state_d  = S_RESP2;
            end
         end
         S_RESP2: begin
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (cnt_q >= DRAIN_LAST) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // first response byte is launched on the transition into RESP0
      if (resp_start) begin
         state_d  = S_RESP0;
         tx_en_d  = 1'b1;
         tx_dat_d = SOF_TX;
         if ((status_d != ST_OK) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      end

      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= 8'h00;
         chk_q       <= 8'h00;
         status_q    <= 8'h00;
         rdata_q     <= 8'h00;
         tx_en_q     <= 1'b0;
         tx_dat_q    <= 8'h00;
         cmd_valid_q <= 1'b0;
         cmd_wr_q    <= 1'b0;
         cmd_addr_q  <= 16'h0000;
         cmd_wdat_q  <= 8'h00;
         err_cnt_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         chk_q       <= chk_d;
         status_q    <= status_d;
         rdata_q     <= rdata_d;
         tx_en_q     <= tx_en_d;
         tx_dat_q    <= tx_dat_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_wr_q    <= cmd_wr_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdat_q  <= cmd_wdat_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign tx_en     = tx_en_q;
   assign tx_dat    = tx_dat_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_wr    = cmd_wr_q;
   assign cmd_addr  = cmd_addr_q;
   assign cmd_wdat  = cmd_wdat_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frame table, hand-written corner
// sequences and random frames against a frame-level reference model.
module tb_uart_cmd_parser;

   localparam int unsigned GAP    = 16;
   localparam int unsigned TMO    = 300;
   localparam int unsigned CW     = 20;
   localparam int unsigned BUDGET = TMO + 4 * GAP + 200;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_dat;
   logic        rx_rdy;
   logic        tx_en;
   logic [7:0]  tx_dat;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdat;
   logic        cmd_done;
   logic [7:0]  cmd_rdat;
   logic [7:0]  err_cnt;

   uart_cmd_parser #(.byte_gap(GAP), .timeout(TMO), .cnt_width(CW)) dut (
      .clk(clk), .rst_n(rst_n), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
      .tx_en(tx_en), .tx_dat(tx_dat), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdat(cmd_wdat), .cmd_done(cmd_done),
      .cmd_rdat(cmd_rdat), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // transmitted bytes and the cycle of each tx_en pulse
   logic [7:0]  txq [$];
   int unsigned txt [$];
   always @(negedge clk) begin
      if (tx_en === 1'b1) begin
         txq.push_back(tx_dat);
         txt.push_back(cyc);
      end
   end

   // fake EEPROM controller
   logic [7:0]  mem [256];
   int unsigned cfg_rdy_dly  = 0;
   int unsigned cfg_done_dly = 1;
   bit          cfg_done_ok  = 1'b1;
   int unsigned req_seen = 0;
   int unsigned req_cyc  = 0;
   int unsigned req_hold = 0;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [7:0]  req_wdat;

   initial begin
      cmd_ready = 1'b0;
      cmd_done  = 1'b0;
      cmd_rdat  = 8'h00;
      forever begin
         @(posedge clk); #1;
         cmd_ready = (cfg_rdy_dly == 0);
         if (cmd_valid === 1'b1) begin
            req_seen++;
            req_cyc  = cyc;
            req_wr   = cmd_wr;
            req_addr = cmd_addr;
            req_wdat = cmd_wdat;
            req_hold = 1;
            for (int i = 0; i < int'(cfg_rdy_dly); i++) begin
               @(posedge clk); #1;
               if (cmd_valid === 1'b1 && cmd_wr === req_wr && cmd_addr === req_addr &&
                   cmd_wdat === req_wdat) req_hold++;
            end
            cmd_ready = 1'b1;
            @(posedge clk); #1;
            cmd_ready = (cfg_rdy_dly == 0);
            check("valid_drop", 32'(cmd_valid), 32'(0));
            if (cfg_done_ok) begin
               for (int i = 1; i < int'(cfg_done_dly); i++) begin
                  @(posedge clk); #1;
               end
               cmd_done = 1'b1;
               cmd_rdat = req_wr ? ~req_wdat : mem[req_addr[7:0]];
               if (req_wr) mem[req_addr[7:0]] = req_wdat;
               @(posedge clk); #1;
               cmd_done = 1'b0;
            end
         end
      end
   end

   function automatic logic [7:0] fb(input logic [47:0] f, input int i);
      return f[47 - 8 * i -: 8];
   endfunction

   // frame-level reference: status and read-back byte from the protocol rules
   function automatic void ref_resp(input logic [47:0] f, input bit done_ok,
                                    output logic [7:0] st, output logic [7:0] rd, output bit iss);
      logic [7:0] op;
      logic [7:0] sum;
      op  = fb(f, 1);
      sum = fb(f, 1) ^ fb(f, 2) ^ fb(f, 3) ^ fb(f, 4);
      iss = 1'b0;
      rd  = 8'h00;
      if (sum != fb(f, 5)) st = 8'hE1;
      else if (op != 8'h01 && op != 8'h02) st = 8'hE2;
      else begin
         iss = 1'b1;
         if (!done_ok) st = 8'hE3;
         else begin
            st = 8'h00;
            rd = (op == 8'h01) ? fb(f, 4) : mem[fb(f, 3)];
         end
      end
   endfunction

   int unsigned last_rx_cyc = 0;
   int unsigned model_err   = 0;

   task automatic send_byte(input logic [7:0] b);
      rx_dat      = b;
      rx_rdy      = 1'b1;
      last_rx_cyc = cyc;
      @(posedge clk); #1;
      rx_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input string tag, input logic [7:0] st, input logic [7:0] rd, input bit quiet);
      int unsigned n;
      n = 0;
      while (txq.size() < 3 && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      if (txq.size() < 3) begin
         check({tag, "_resp_count"}, 32'(txq.size()), 32'(3));
      end else if (!quiet) begin
         check({tag, "_byte0"}, 32'(txq[0]), 32'(8'h5A));
         check({tag, "_status"}, 32'(txq[1]), 32'(st));
         check({tag, "_rdata"}, 32'(txq[2]), 32'(rd));
         check({tag, "_gap01"}, 32'(txt[1] - txt[0]), 32'(GAP));
         check({tag, "_gap12"}, 32'(txt[2] - txt[1]), 32'(GAP));
      end
      repeat (GAP + 4) @(posedge clk);
      #1;
      if (!quiet) check({tag, "_no_extra"}, 32'(txq.size()), 32'(3));
      txq.delete();
      txt.delete();
   endtask

   task automatic run_frame(input string tag, input logic [47:0] f, input int unsigned rdly,
                            input int unsigned ddly, input bit dok, input logic [7:0] est,
                            input logic [7:0] erd, input bit eiss, input bit quiet);
      int unsigned seen0;
      cfg_rdy_dly  = rdly;
      cfg_done_dly = ddly;
      cfg_done_ok  = dok;
      if (est != 8'h00 && model_err < 255) model_err++;
      seen0 = req_seen;
      for (int i = 0; i < 6; i++) send_byte(fb(f, i));
      wait_resp(tag, est, erd, quiet);
      if (!quiet) begin
         check({tag, "_issued"}, 32'(req_seen - seen0), 32'(eiss));
         if (eiss) begin
            check({tag, "_valid_lat"}, 32'(req_cyc), 32'(last_rx_cyc + 1));
            check({tag, "_wr"}, 32'(req_wr), 32'(fb(f, 1) == 8'h01));
            check({tag, "_addr"}, 32'(req_addr), 32'({fb(f, 2), fb(f, 3)}));
            check({tag, "_wdat"}, 32'(req_wdat), 32'(fb(f, 4)));
            check({tag, "_valid_hold"}, 32'(req_hold), 32'(rdly + 1));
         end
         check({tag, "_err_cnt"}, 32'(err_cnt), 32'(model_err));
      end
   endtask

   typedef struct {
      logic [47:0] frame;
      int unsigned rdly;
      int unsigned ddly;
      logic [7:0]  est;
      logic [7:0]  erd;
      bit          eiss;
   } vec_t;

   vec_t        vecs [4];
   logic [47:0] f;
   logic [7:0]  c, ah, al, d, k, st, rd;
   bit          iss, dok;
   int unsigned seen0;
   int unsigned n;

   initial begin
      rst_n  = 1'b0;
      rx_dat = 8'h00;
      rx_rdy = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;
      mem[8'h23] = 8'h7E;

      vecs[0] = '{48'hA5_01_00_10_3C_2D, 0, 50, 8'h00, 8'h3C, 1'b1};
      vecs[1] = '{48'hA5_02_01_23_00_20, 10, 5, 8'h00, 8'h7E, 1'b1};
      vecs[2] = '{48'hA5_01_00_10_3C_00, 0, 1, 8'hE1, 8'h00, 1'b0};
      vecs[3] = '{48'hA5_07_00_00_00_07, 0, 1, 8'hE2, 8'h00, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_en", 32'(tx_en), 32'(0));
      check("rst_tx_dat", 32'(tx_dat), 32'(0));
      check("rst_cmd_valid", 32'(cmd_valid), 32'(0));
      check("rst_cmd_wr", 32'(cmd_wr), 32'(0));
      check("rst_cmd_addr", 32'(cmd_addr), 32'(0));
      check("rst_cmd_wdat", 32'(cmd_wdat), 32'(0));
      check("rst_err_cnt", 32'(err_cnt), 32'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].rdly, vecs[i].ddly, 1'b1,
                   vecs[i].est, vecs[i].erd, vecs[i].eiss, 1'b0);

      // garbage, then a partial frame abandoned by the inter-byte timeout
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      repeat (TMO + 10) @(posedge clk);
      #1;
      check("partial_silent", 32'(txq.size()), 32'(0));
      check("partial_err_cnt", 32'(err_cnt), 32'(model_err));
      run_frame("after_tmo", 48'hA5_02_01_23_00_20, 0, 3, 1'b1, 8'h00, 8'h7E, 1'b1, 1'b0);

      // EEPROM never completes; a frame sent during the response is dropped
      cfg_rdy_dly  = 0;
      cfg_done_ok  = 1'b0;
      seen0        = req_seen;
      if (model_err < 255) model_err++;
      f = 48'hA5_01_00_44_99_DC;
      for (int i = 0; i < 6; i++) send_byte(fb(f, i));
      n = 0;
      while (txq.size() < 1 && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      check("wtmo_first_byte", 32'(txq.size() >= 1), 32'(1));
      f = 48'hA5_02_01_23_00_20;
      for (int i = 0; i < 6; i++) send_byte(fb(f, i));
      wait_resp("wait_tmo", 8'hE3, 8'h00, 1'b0);
      check("wait_tmo_issued", 32'(req_seen - seen0), 32'(1));
      check("wait_tmo_err_cnt", 32'(err_cnt), 32'(model_err));

      // reset pulse in the middle of a response
      cfg_done_ok = 1'b1;
      f = 48'hA5_07_12_34_56_77;
      for (int i = 0; i < 6; i++) send_byte(fb(f, i));
      n = 0;
      while (txq.size() < 2 && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_mid_reached", 32'(txq.size()), 32'(2));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mid_rst_tx_en", 32'(tx_en), 32'(0));
      check("mid_rst_tx_dat", 32'(tx_dat), 32'(0));
      check("mid_rst_cmd_valid", 32'(cmd_valid), 32'(0));
      check("mid_rst_cmd_addr", 32'(cmd_addr), 32'(0));
      check("mid_rst_cmd_wdat", 32'(cmd_wdat), 32'(0));
      check("mid_rst_err_cnt", 32'(err_cnt), 32'(0));
      repeat (3 * GAP) @(posedge clk);
      #1;
      check("mid_rst_no_tx", 32'(txq.size()), 32'(2));
      txq.delete();
      txt.delete();
      model_err = 0;
      run_frame("post_rst", 48'hA5_01_00_10_3C_2D, 0, 4, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b0);

      // random frames against the reference model
      for (int r = 0; r < 20; r++) begin
         case ($urandom_range(0, 3))
            0, 3:    c = 8'h01;
            1:       c = 8'h02;
            default: c = 8'($urandom);
         endcase
         ah = 8'($urandom);
         al = 8'($urandom);
         d  = 8'($urandom);
         k  = c ^ ah ^ al ^ d;
         if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
         f   = {8'hA5, c, ah, al, d, k};
         dok = ($urandom_range(0, 7) != 0);
         ref_resp(f, dok, st, rd, iss);
         run_frame($sformatf("rnd%0d", r), f, $urandom_range(0, 3), $urandom_range(1, 8),
                   dok, st, rd, iss, 1'b0);
      end

      // error counter saturation
      for (int r = 0; r < 260; r++)
         run_frame("sat", 48'hA5_07_00_00_00_07, 0, 1, 1'b1, 8'hE2, 8'h00, 1'b0, 1'b1);
      check("err_cnt_model_sat", 32'(model_err), 32'(255));
      check("err_cnt_sat", 32'(err_cnt), 32'(model_err));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
